arch_sched: RTL and testbench



---
 rtl/arch_sched_if.sv | 26 ++
 rtl/arch_sched.sv | 98 +++++++++
 tb/tb_arch_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/arch_sched_if.sv
// Requester/capture-side bundle for arch_sched: request inputs, phase, grant and capture data.
// req is a level held until gnt[i] pulses for one cycle; the requester drops it on the next edge.
interface arch_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4
);
  logic               enable;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [2:0]         clk_out;
  logic [DW-1:0]      a0;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [7:0]         cap_cnt;
  logic               state_dbg;

  modport master (
    output enable, req, req_data,
    input  clk_out, a0, gnt, busy, cap_cnt, state_dbg
  );

  modport slave (
    input  enable, req, req_data,
    output clk_out, a0, gnt, busy, cap_cnt, state_dbg
  );
endinterface

// File: rtl/arch_sched.sv
// Phase sequencer and 4-way round-robin arbiter feeding the shared 4-bit capture register.
// The capture register loads a0 on phases 4 and 6; grants are issued on the edges entering them.
module arch_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  arch_sched_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [2:0]      clk_out_q;
  logic [DW-1:0]   a0_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic [7:0]      cap_cnt_q;
  logic [1:0]      rr;

  logic [1:0]      winner;
  logic [1:0]      cand;
  logic            found;
  logic            arb_pt;
  logic [DW-1:0]   win_data;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr + 2'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_data = bus.req_data[DW*int'(winner) +: DW];

  // Arbitrate only while actually counting, on the edge into phase 4 or 6.
  assign arb_pt = (state == RUN) && bus.enable &&
                  ((clk_out_q == 3'd3) || (clk_out_q == 3'd5));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_out_q <= 3'd0;
      a0_q      <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      cap_cnt_q <= 8'd0;
      rr        <= 2'd0;
    end else begin
      gnt_q <= '0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.enable) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            clk_out_q <= clk_out_q + 3'd1;
            if (arb_pt && found) begin
              gnt_q     <= NREQ'(1) << winner;
              a0_q      <= win_data;
              rr        <= winner + 2'd1;
              cap_cnt_q <= cap_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out   = clk_out_q;
  assign bus.a0        = a0_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.cap_cnt   = cap_cnt_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_arch_sched.sv
// Directed bench for arch_sched: grants are predicted into a queue and checked by a negedge monitor.
module tb_arch_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arch_sched_if #(.NREQ(4), .DW(4)) bus ();

  arch_sched #(.NREQ(4), .DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;
  logic [3:0]  cap_q = 4'd0;

  // Behavioural stand-in for the capture register downstream.
  always @(posedge clk)
    if (bus.clk_out == 3'd4 || bus.clk_out == 3'd6) cap_q <= bus.a0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_gnt(input logic [3:0] g, input logic [3:0] d,
                            input logic [7:0] c, input logic [2:0] ph);
    exp_q.push_back({g, d, c, ph});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int i;
    i = 0;
    while (bus.clk_out !== p && i < 20) begin
      step(1);
      i++;
    end
    check("wait_phase", 32'(bus.clk_out), 32'(p));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk_out"}, 32'(bus.clk_out), 32'd0);
    check({tag, "_a0"},      32'(bus.a0),      32'd0);
    check({tag, "_gnt"},     32'(bus.gnt),     32'd0);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_cap_cnt"}, 32'(bus.cap_cnt), 32'd0);
    check({tag, "_state"},   32'(bus.state_dbg), 32'd0);
  endtask

  // Monitor: every grant the DUT presents must match the next predicted one.
  always @(negedge clk) begin
    if (rst_n && bus.gnt != 4'd0) begin
      if (exp_q.size() == 0) begin
        check("gnt_unexpected", 32'(bus.gnt), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_gnt",     32'(bus.gnt),     32'(mon_e[18:15]));
        check("sb_a0",      32'(bus.a0),      32'(mon_e[14:11]));
        check("sb_cap_cnt", 32'(bus.cap_cnt), 32'(mon_e[10:3]));
        check("sb_phase",   32'(bus.clk_out), 32'(mon_e[2:0]));
      end
    end
  end

  initial begin
    #100000;
    check("watchdog", 32'd1, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    int t;
    int ng;
    bus.enable   = 1'b0;
    bus.req      = 4'd0;
    bus.req_data = 16'd0;

    // Reset values
    #12;
    check_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Free-running phase with no requests
    bus.enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("t1_phase",   32'(bus.clk_out), 32'(i % 8));
      check("t1_gnt",     32'(bus.gnt),     32'd0);
      check("t1_a0",      32'(bus.a0),      32'd0);
      check("t1_cap_cnt", 32'(bus.cap_cnt), 32'd0);
    end
    check("t1_busy", 32'(bus.busy), 32'd1);

    // Single requester
    bus.req_data = 16'h000A;
    bus.req      = 4'b0001;
    expect_gnt(4'b0001, 4'hA, 8'd1, 3'd4);
    t = 0;
    do begin
      step(1);
      t++;
    end while (bus.gnt == 4'd0 && t < 20);
    check("t2_gnt", 32'(bus.gnt), 32'd1);
    bus.req = 4'd0;
    check("t2_a0", 32'(bus.a0), 32'hA);
    step(1);
    check("t2_capture", 32'(cap_q), 32'hA);
    check("t2_gnt_clear", 32'(bus.gnt), 32'd0);

    // Reset, then all four contending continuously
    rst_n = 1'b0;
    bus.req_data = 16'h4321;
    bus.req      = 4'b1111;
    expect_gnt(4'b0001, 4'h1, 8'd1, 3'd4);
    expect_gnt(4'b0010, 4'h2, 8'd2, 3'd6);
    expect_gnt(4'b0100, 4'h3, 8'd3, 3'd4);
    expect_gnt(4'b1000, 4'h4, 8'd4, 3'd6);
    expect_gnt(4'b0001, 4'h1, 8'd5, 3'd4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ng = 0;
    t  = 0;
    while (ng < 5 && t < 60) begin
      step(1);
      t++;
      if (bus.gnt != 4'd0) ng++;
    end
    bus.req = 4'd0;
    check("t3_grants", 32'(ng), 32'd5);
    check("t3_a0", 32'(bus.a0), 32'h1);

    // Freeze at phase 3 with a request pending: no arbitration while frozen
    wait_phase(3'd3);
    bus.enable   = 1'b0;
    bus.req_data = 16'h0050;
    bus.req      = 4'b0010;
    expect_gnt(4'b0010, 4'h5, 8'd6, 3'd4);
    step(1);
    check("t4_phase",  32'(bus.clk_out), 32'd3);
    check("t4_gnt",    32'(bus.gnt),     32'd0);
    check("t4_busy",   32'(bus.busy),    32'd0);
    step(3);
    check("t4_phase_hold", 32'(bus.clk_out), 32'd3);
    check("t4_gnt_hold",   32'(bus.gnt),     32'd0);
    bus.enable = 1'b1;
    step(1);
    check("t4_resume_phase", 32'(bus.clk_out), 32'd3);
    check("t4_resume_busy",  32'(bus.busy),    32'd1);
    step(1);
    check("t4_gnt_after", 32'(bus.gnt), 32'b0010);

    // Freeze at phase 4 right after that grant
    bus.enable = 1'b0;
    bus.req    = 4'd0;
    step(1);
    check("t5_gnt_clear", 32'(bus.gnt),     32'd0);
    check("t5_phase",     32'(bus.clk_out), 32'd4);
    check("t5_a0",        32'(bus.a0),      32'h5);
    check("t5_capture",   32'(cap_q),       32'h5);
    step(2);
    check("t5_phase_hold",   32'(bus.clk_out), 32'd4);
    check("t5_a0_hold",      32'(bus.a0),      32'h5);
    check("t5_capture_hold", 32'(cap_q),       32'h5);
    bus.enable = 1'b1;
    step(1);
    check("t5_resume_phase", 32'(bus.clk_out), 32'd4);
    step(1);
    check("t5_next_phase", 32'(bus.clk_out), 32'd5);

    // Asynchronous reset while a grant is showing
    wait_phase(3'd3);
    bus.req_data = 16'h900C;
    bus.req      = 4'b1010;
    expect_gnt(4'b1000, 4'h9, 8'd7, 3'd4);
    step(1);
    check("t6_gnt", 32'(bus.gnt), 32'b1000);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    bus.req = 4'b1001;
    expect_gnt(4'b0001, 4'hC, 8'd1, 3'd4);
    expect_gnt(4'b1000, 4'h9, 8'd2, 3'd6);
    @(posedge clk); #1;
    rst_n = 1'b1;
    t = 0;
    while (bus.req != 4'd0 && t < 40) begin
      step(1);
      t++;
      if (bus.gnt[0]) bus.req[0] = 1'b0;
      if (bus.gnt[3]) bus.req[3] = 1'b0;
    end
    check("t6_req_served", 32'(bus.req),     32'd0);
    check("t6_phase",      32'(bus.clk_out), 32'd6);

    // 256 grants: capture counter wraps
    bus.req_data = 16'h4321;
    bus.req      = 4'b1111;
    for (int k = 0; k < 256; k++)
      expect_gnt(4'(1 << (k % 4)), 4'((k % 4) + 1), 8'(3 + k), ((k % 2) == 0) ? 3'd4 : 3'd6);
    ng = 0;
    t  = 0;
    while (ng < 256 && t < 1200) begin
      step(1);
      t++;
      if (bus.gnt != 4'd0) begin
        ng++;
        if (ng == 254) check("t7_wrap_zero", 32'(bus.cap_cnt), 32'd0);
      end
    end
    bus.req = 4'd0;
    check("t7_grants",  32'(ng),          32'd256);
    check("t7_cap_cnt", 32'(bus.cap_cnt), 32'd2);
    check("t7_a0",      32'(bus.a0),      32'h4);
    step(4);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
